sys_cmd_ctrl: RTL and testbench

Command controller between the UART receive/transmit path, the register file and the ALU in the system top. Decodes the four-command byte protocol (register write, register read, ALU op with operands, ALU op on stored operands). Sequences register-file and ALU accesses. Returns read data and ALU results to the TX path as bytes. All sides sit in the reference clock domain; the RX and TX streams are already synchronised.

---
 rtl/sys_ctrl_pkg.sv | 57 +++++
 rtl/ctrl_tx_seq.sv | 66 ++++++
 rtl/sys_cmd_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_ctrl_pkg
// Brief    : Shared constants and types for the system command controller:
//            command codes, ALU operand addresses, ALU function codes and
//            the controller FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

  // Command bytes recognised in IDLE
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations holding the ALU operands
  localparam int unsigned ALU_OPA_ADDR = 0;
  localparam int unsigned ALU_OPB_ADDR = 1;

  // ALU function codes
  typedef enum logic [3:0] {
    FUN_ADD    = 4'd0,
    FUN_SUB    = 4'd1,
    FUN_MUL    = 4'd2,
    FUN_DIV    = 4'd3,
    FUN_AND    = 4'd4,
    FUN_OR     = 4'd5,
    FUN_NAND   = 4'd6,
    FUN_NOR    = 4'd7,
    FUN_XOR    = 4'd8,
    FUN_XNOR   = 4'd9,
    FUN_CMP_EQ = 4'd10,
    FUN_CMP_GT = 4'd11,
    FUN_CMP_LT = 4'd12,
    FUN_SHR    = 4'd13,
    FUN_SHL    = 4'd14,
    FUN_NOP    = 4'd15
  } alu_fun_t;

  // Controller FSM states
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FUN  = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_BYTE0 = 4'd9,
    ST_TX_BYTE1 = 4'd10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_tx_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_tx_seq
// Brief    : Response byte sequencer. Captures a one- or two-byte response,
//            emits it low byte first into the TX FIFO while honouring
//            TX_FULL, and reports progress back to the controller FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_tx_seq
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic                    i_two,
  input  logic                    i_tx_full,
  output logic [DATA_WIDTH-1:0]   o_tx_p_data,
  output logic                    o_tx_d_vld,
  output logic                    o_done,
  output logic                    o_lo_sent
);

  logic [2*DATA_WIDTH-1:0] r_buf;
  logic [1:0]              r_cnt;
  logic [DATA_WIDTH-1:0]   r_tx_p_data;
  logic                    r_tx_d_vld;

  // Load a response and push out one byte per cycle whenever the FIFO has room;
  // a byte offered on the load cycle goes out immediately to keep latency at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf       <= '0;
      r_cnt       <= 2'd0;
      r_tx_p_data <= '0;
      r_tx_d_vld  <= 1'b0;
    end else begin
      r_tx_d_vld <= 1'b0;
      if (i_load) begin
        if (!i_tx_full) begin
          r_tx_p_data <= i_data[DATA_WIDTH-1:0];
          r_tx_d_vld  <= 1'b1;
          r_buf       <= {{DATA_WIDTH{1'b0}}, i_data[2*DATA_WIDTH-1:DATA_WIDTH]};
          r_cnt       <= i_two ? 2'd1 : 2'd0;
        end else begin
          r_buf <= i_data;
          r_cnt <= i_two ? 2'd2 : 2'd1;
        end
      end else if ((r_cnt != 2'd0) && !i_tx_full) begin
        r_tx_p_data <= r_buf[DATA_WIDTH-1:0];
        r_tx_d_vld  <= 1'b1;
        r_buf       <= {{DATA_WIDTH{1'b0}}, r_buf[2*DATA_WIDTH-1:DATA_WIDTH]};
        r_cnt       <= r_cnt - 2'd1;
      end
    end
  end

  assign o_tx_p_data = r_tx_p_data;
  assign o_tx_d_vld  = r_tx_d_vld;
  assign o_done      = (r_cnt == 2'd0);
  assign o_lo_sent   = (r_cnt != 2'd2);

endmodule
`default_nettype wire

// File: rtl/sys_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sys_cmd_ctrl
// Brief    : Command controller between UART RX/TX, register file and ALU.
//            Decodes write / read / ALU-op / ALU-no-operand commands,
//            sequences RF and ALU accesses, returns results as TX bytes.
// Revision : 1.0 - initial release
// ============================================================================
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDRESS,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_FULL
);

  state_t                  r_state;
  logic                    r_wr_en;
  logic                    r_rd_en;
  logic                    r_alu_en;
  logic                    r_alu_clk_en;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [FUN_WIDTH-1:0]    r_alu_fun;
  logic                    r_two;

  logic                    w_tx_load;
  logic                    w_tx_two;
  logic [2*DATA_WIDTH-1:0] w_tx_data;
  logic                    w_tx_done;
  logic                    w_tx_lo_sent;

  // A response is captured the cycle its source data is valid in a wait state
  always_comb begin
    w_tx_load = 1'b0;
    w_tx_two  = 1'b0;
    w_tx_data = ALU_OUT;
    if ((r_state == ST_RD_WAIT) && RF_RD_DATA_VLD) begin
      w_tx_load = 1'b1;
      w_tx_data = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
    end else if ((r_state == ST_ALU_WAIT) && ALU_OUT_VLD) begin
      w_tx_load = 1'b1;
      w_tx_two  = 1'b1;
    end
  end

  // Command decode and access sequencing; strobes default low so each is one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_alu_en     <= 1'b0;
      r_alu_clk_en <= 1'b0;
      r_address    <= '0;
      r_wr_data    <= '0;
      r_alu_fun    <= '0;
      r_two        <= 1'b0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_alu_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
              r_state <= ST_WR_ADDR;
            end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
              r_state <= ST_RD_ADDR;
            end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
              r_state <= ST_ALU_A;
            end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
              r_state      <= ST_ALU_FUN;
              r_alu_clk_en <= 1'b1;
            end
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            r_address <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state   <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_address <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_rd_en   <= 1'b1;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (RF_RD_DATA_VLD) begin
            r_two   <= 1'b0;
            r_state <= ST_TX_BYTE0;
          end
        end
        ST_ALU_A: begin
          if (RX_D_VLD) begin
            r_address <= ADDR_WIDTH'(ALU_OPA_ADDR);
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
            r_state   <= ST_ALU_B;
          end
        end
        ST_ALU_B: begin
          if (RX_D_VLD) begin
            r_address    <= ADDR_WIDTH'(ALU_OPB_ADDR);
            r_wr_data    <= RX_P_DATA;
            r_wr_en      <= 1'b1;
            r_alu_clk_en <= 1'b1;
            r_state      <= ST_ALU_FUN;
          end
        end
        ST_ALU_FUN: begin
          if (RX_D_VLD) begin
            r_alu_fun <= RX_P_DATA[FUN_WIDTH-1:0];
            r_alu_en  <= 1'b1;
            r_state   <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            r_alu_clk_en <= 1'b0;
            r_two        <= 1'b1;
            r_state      <= ST_TX_BYTE0;
          end
        end
        ST_TX_BYTE0: begin
          if (r_two) begin
            if (w_tx_lo_sent) r_state <= ST_TX_BYTE1;
          end else if (w_tx_done) begin
            r_state <= ST_IDLE;
          end
        end
        ST_TX_BYTE1: begin
          if (w_tx_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ctrl_tx_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_seq (
    .clk         (CLK),
    .rst         (RST),
    .i_load      (w_tx_load),
    .i_data      (w_tx_data),
    .i_two       (w_tx_two),
    .i_tx_full   (TX_FULL),
    .o_tx_p_data (TX_P_DATA),
    .o_tx_d_vld  (TX_D_VLD),
    .o_done      (w_tx_done),
    .o_lo_sent   (w_tx_lo_sent)
  );

  assign RF_WR_EN   = r_wr_en;
  assign RF_RD_EN   = r_rd_en;
  assign RF_ADDRESS = r_address;
  assign RF_WR_DATA = r_wr_data;
  assign ALU_EN     = r_alu_en;
  assign ALU_FUN    = r_alu_fun;
  assign ALU_CLK_EN = r_alu_clk_en;

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_cmd_ctrl
// Brief    : Directed self-checking bench for sys_cmd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_cmd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DW-1:0]   RX_P_DATA = '0;
  logic            RX_D_VLD = 1'b0;
  logic            RF_WR_EN;
  logic            RF_RD_EN;
  logic [AW-1:0]   RF_ADDRESS;
  logic [DW-1:0]   RF_WR_DATA;
  logic [DW-1:0]   RF_RD_DATA = '0;
  logic            RF_RD_DATA_VLD = 1'b0;
  logic            ALU_EN;
  logic [FW-1:0]   ALU_FUN;
  logic            ALU_CLK_EN;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic            ALU_OUT_VLD = 1'b0;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  logic            TX_FULL = 1'b0;

  int total = 0;
  int bad   = 0;

  int            wr_cnt  = 0;
  int            rd_cnt  = 0;
  int            alu_cnt = 0;
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  logic [DW-1:0] tx_log[$];

  always #5 CLK = ~CLK;

  sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDRESS(RF_ADDRESS),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_CLK_EN(ALU_CLK_EN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL)
  );

  // Log every strobe seen at the falling edge (one entry per one-cycle pulse)
  always @(negedge CLK) begin
    if (!RST) begin
      if (RF_WR_EN) begin
        wr_cnt++;
        wr_addr_log.push_back(RF_ADDRESS);
        wr_data_log.push_back(RF_WR_DATA);
      end
      if (RF_RD_EN) rd_cnt++;
      if (ALU_EN)   alu_cnt++;
      if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
    end
  end

  task automatic send_byte(input logic [DW-1:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic pulse_rd(input logic [DW-1:0] d);
    @(negedge CLK);
    RF_RD_DATA     = d;
    RF_RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RF_RD_DATA_VLD = 1'b0;
  endtask

  task automatic pulse_alu(input logic [2*DW-1:0] r);
    @(negedge CLK);
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++;
    if ({RF_WR_EN, RF_RD_EN, ALU_EN, ALU_CLK_EN, TX_D_VLD} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 00000", {RF_WR_EN, RF_RD_EN, ALU_EN, ALU_CLK_EN, TX_D_VLD});
    end
    total++;
    if ({RF_ADDRESS, RF_WR_DATA, ALU_FUN, TX_P_DATA} !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%h wd=%h fun=%h tx=%h want all 0", RF_ADDRESS, RF_WR_DATA, ALU_FUN, TX_P_DATA);
    end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    int w0 = wr_cnt;
    int t0 = tx_log.size();
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    total++;
    if (RF_WR_EN !== 1'b1 || RF_ADDRESS !== 4'h5 || RF_WR_DATA !== 8'h3C) begin
      bad++; $display("FAIL write_strobe: got en=%b addr=%h data=%h want 1/5/3c", RF_WR_EN, RF_ADDRESS, RF_WR_DATA);
    end
    idle(4);
    total++;
    if (wr_cnt - w0 !== 1 || tx_log.size() - t0 !== 0) begin
      bad++; $display("FAIL write_counts: got wr=%0d tx=%0d want 1/0", wr_cnt - w0, tx_log.size() - t0);
    end
  endtask

  task automatic test_read();
    int r0 = rd_cnt;
    int t0 = tx_log.size();
    send_byte(8'hBB);
    send_byte(8'h05);
    total++;
    if (RF_RD_EN !== 1'b1 || RF_ADDRESS !== 4'h5) begin
      bad++; $display("FAIL read_strobe: got en=%b addr=%h want 1/5", RF_RD_EN, RF_ADDRESS);
    end
    idle(3);
    pulse_rd(8'h3C);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h3C) begin
      bad++; $display("FAIL read_tx: got vld=%b data=%h want 1/3c", TX_D_VLD, TX_P_DATA);
    end
    idle(4);
    total++;
    if (rd_cnt - r0 !== 1 || tx_log.size() - t0 !== 1) begin
      bad++; $display("FAIL read_counts: got rd=%0d tx=%0d want 1/1", rd_cnt - r0, tx_log.size() - t0);
    end
  endtask

  task automatic test_alu_op();
    int w0 = wr_cnt;
    int t0 = tx_log.size();
    send_byte(8'hCC);
    send_byte(8'h08);
    total++;
    if (ALU_CLK_EN !== 1'b0) begin
      bad++; $display("FAIL alu_clk_en_early: got %b want 0", ALU_CLK_EN);
    end
    send_byte(8'h07);
    total++;
    if (ALU_CLK_EN !== 1'b1) begin
      bad++; $display("FAIL alu_clk_en_fun: got %b want 1", ALU_CLK_EN);
    end
    send_byte(8'h00);
    total++;
    if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h0 || ALU_CLK_EN !== 1'b1) begin
      bad++; $display("FAIL alu_start: got en=%b fun=%h clken=%b want 1/0/1", ALU_EN, ALU_FUN, ALU_CLK_EN);
    end
    total++;
    if (wr_cnt - w0 !== 2 || wr_addr_log[w0] !== 4'h0 || wr_data_log[w0] !== 8'h08 ||
        wr_addr_log[w0+1] !== 4'h1 || wr_data_log[w0+1] !== 8'h07) begin
      bad++; $display("FAIL alu_operand_writes: got n=%0d a0=%h d0=%h a1=%h d1=%h want 2/0/08/1/07",
                      wr_cnt - w0, wr_addr_log[w0], wr_data_log[w0], wr_addr_log[w0+1], wr_data_log[w0+1]);
    end
    idle(2);
    pulse_alu(16'h000F);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h0F || ALU_CLK_EN !== 1'b0) begin
      bad++; $display("FAIL alu_tx_lo: got vld=%b data=%h clken=%b want 1/0f/0", TX_D_VLD, TX_P_DATA, ALU_CLK_EN);
    end
    @(negedge CLK);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h00) begin
      bad++; $display("FAIL alu_tx_hi: got vld=%b data=%h want 1/00", TX_D_VLD, TX_P_DATA);
    end
    idle(4);
    total++;
    if (tx_log.size() - t0 !== 2 || ALU_CLK_EN !== 1'b0) begin
      bad++; $display("FAIL alu_after: got tx=%0d clken=%b want 2/0", tx_log.size() - t0, ALU_CLK_EN);
    end
  endtask

  task automatic test_alu_nop();
    int w0 = wr_cnt;
    int a0 = alu_cnt;
    int t0 = tx_log.size();
    send_byte(8'hDD);
    total++;
    if (ALU_CLK_EN !== 1'b1) begin
      bad++; $display("FAIL nop_clk_en: got %b want 1", ALU_CLK_EN);
    end
    send_byte(8'h0D);
    total++;
    if (ALU_EN !== 1'b1 || ALU_FUN !== 4'hD) begin
      bad++; $display("FAIL nop_start: got en=%b fun=%h want 1/d", ALU_EN, ALU_FUN);
    end
    idle(1);
    pulse_alu(16'h000A);
    idle(4);
    total++;
    if (wr_cnt - w0 !== 0 || alu_cnt - a0 !== 1 || tx_log.size() - t0 !== 2 ||
        tx_log[t0] !== 8'h0A || tx_log[t0+1] !== 8'h00) begin
      bad++; $display("FAIL nop_result: got wr=%0d alu=%0d tx=%0d b0=%h b1=%h want 0/1/2/0a/00",
                      wr_cnt - w0, alu_cnt - a0, tx_log.size() - t0, tx_log[t0], tx_log[t0+1]);
    end
  endtask

  task automatic test_backpressure();
    int t0 = tx_log.size();
    TX_FULL = 1'b1;
    send_byte(8'hCC);
    send_byte(8'h08);
    send_byte(8'h07);
    send_byte(8'h00);
    idle(1);
    pulse_alu(16'h12AB);
    idle(8);
    total++;
    if (TX_D_VLD !== 1'b0 || tx_log.size() - t0 !== 0) begin
      bad++; $display("FAIL bp_hold: got vld=%b tx=%0d want 0/0", TX_D_VLD, tx_log.size() - t0);
    end
    @(negedge CLK);
    TX_FULL = 1'b0;
    @(negedge CLK);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hAB) begin
      bad++; $display("FAIL bp_lo: got vld=%b data=%h want 1/ab", TX_D_VLD, TX_P_DATA);
    end
    @(negedge CLK);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h12) begin
      bad++; $display("FAIL bp_hi: got vld=%b data=%h want 1/12", TX_D_VLD, TX_P_DATA);
    end
    idle(4);
    total++;
    if (tx_log.size() - t0 !== 2) begin
      bad++; $display("FAIL bp_count: got %0d want 2", tx_log.size() - t0);
    end
  endtask

  task automatic test_ignore_and_drop();
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    int t0 = tx_log.size();
    send_byte(8'h55);
    pulse_rd(8'h77);
    pulse_alu(16'h7777);
    idle(2);
    total++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || tx_log.size() - t0 !== 0 || ALU_CLK_EN !== 1'b0) begin
      bad++; $display("FAIL ignore_junk: got wr=%0d rd=%0d tx=%0d clken=%b want 0/0/0/0",
                      wr_cnt - w0, rd_cnt - r0, tx_log.size() - t0, ALU_CLK_EN);
    end
    send_byte(8'hBB);
    send_byte(8'h04);
    total++;
    if (RF_RD_EN !== 1'b1 || RF_ADDRESS !== 4'h4) begin
      bad++; $display("FAIL ignore_read: got en=%b addr=%h want 1/4", RF_RD_EN, RF_ADDRESS);
    end
    send_byte(8'hAA);
    pulse_alu(16'h3333);
    pulse_rd(8'h99);
    total++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h99) begin
      bad++; $display("FAIL drop_read_tx: got vld=%b data=%h want 1/99", TX_D_VLD, TX_P_DATA);
    end
    idle(3);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h77);
    idle(2);
    total++;
    if (wr_cnt - w0 !== 1 || wr_addr_log[w0] !== 4'h2 || wr_data_log[w0] !== 8'h77 || tx_log.size() - t0 !== 1) begin
      bad++; $display("FAIL drop_followup: got wr=%0d addr=%h data=%h tx=%0d want 1/2/77/1",
                      wr_cnt - w0, wr_addr_log[w0], wr_data_log[w0], tx_log.size() - t0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    int t0 = tx_log.size();
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    idle(1);
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({RF_WR_EN, RF_RD_EN, ALU_EN, ALU_CLK_EN, TX_D_VLD} !== 5'b0 ||
        RF_ADDRESS !== 4'h0 || RF_WR_DATA !== 8'h00 || ALU_FUN !== 4'h0 || TX_P_DATA !== 8'h00) begin
      bad++; $display("FAIL async_reset: got clken=%b addr=%h wd=%h fun=%h tx=%h want all 0",
                      ALU_CLK_EN, RF_ADDRESS, RF_WR_DATA, ALU_FUN, TX_P_DATA);
    end
    @(negedge CLK);
    RST = 1'b0;
    pulse_alu(16'h5555);
    idle(3);
    total++;
    if (tx_log.size() - t0 !== 0) begin
      bad++; $display("FAIL reset_discard: got tx=%0d want 0", tx_log.size() - t0);
    end
    w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h0A);
    send_byte(8'h5A);
    total++;
    if (RF_WR_EN !== 1'b1 || RF_ADDRESS !== 4'hA || RF_WR_DATA !== 8'h5A) begin
      bad++; $display("FAIL reset_then_write: got en=%b addr=%h data=%h want 1/a/5a", RF_WR_EN, RF_ADDRESS, RF_WR_DATA);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_alu_nop();
    test_backpressure();
    test_ignore_and_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
